// File: rtl/rf_bank_pkg.sv
// Shared register-file definitions: register count, index width and the
// architecturally special register numbers of the MIPS core.
package rf_bank_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_GP   = 5'd28;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: index-to-data selection, $0 forced to zero,
// optional write-first forwarding of the in-flight write.
module rf_read_port
    import rf_bank_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic [ADDR_W-1:0]         addr,
    input  logic [NUM_REGS*WIDTH-1:0] regs_flat,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [WIDTH-1:0]          rdata
);

    logic fwd_hit;

    assign fwd_hit = BYPASS && wr_en && (wr_addr != REG_ZERO) && (wr_addr == addr);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rdata = '0;
        if (fwd_hit) begin
            rdata = wr_data;
        end else if (addr != REG_ZERO) begin
            rdata = regs_flat[addr*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/rf_bank.sv
// 32 x WIDTH register file for the single-cycle MIPS core: two combinational
// read ports, one synchronous write port, one debug read port, $0 reads as zero.
module rf_bank
    import rf_bank_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] SP_INIT = 32'h0000_2ffc,
    parameter logic [WIDTH-1:0] GP_INIT = 32'h0000_1800,
    // Must stay 0 in the single-cycle core: WD is a function of RD1/RD2.
    parameter bit               BYPASS  = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              RFWr,
    input  logic [4:0]        A1,
    input  logic [4:0]        A2,
    input  logic [4:0]        A3,
    input  logic [WIDTH-1:0]  WD,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    input  logic [4:0]        dbg_addr,
    output logic [WIDTH-1:0]  dbg_data,
    output logic [31:0]       wr_count
);

    // $0 has no storage at all.
    logic [WIDTH-1:0]          regs [1:NUM_REGS-1];
    logic [NUM_REGS*WIDTH-1:0] regs_flat;
    logic                      wr_commit;

    assign wr_commit = RFWr && (A3 != REG_ZERO);

    // NOTE: register storage uses non-blocking assignments so every read in the
    // same edge sees pre-edge values.
    // NOTE: the array is reset explicitly because $gp/$sp need defined start values;
    // this keeps it as flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            regs[REG_GP] <= GP_INIT;
            regs[REG_SP] <= SP_INIT;
            wr_count     <= '0;
        end else if (wr_commit) begin
            regs[A3] <= WD;
            wr_count <= wr_count + 32'd1;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_flat[i*WIDTH +: WIDTH] = regs[i];
        end
    end

    rf_read_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_rd1 (
        .addr      (A1),
        .regs_flat (regs_flat),
        .wr_en     (RFWr),
        .wr_addr   (A3),
        .wr_data   (WD),
        .rdata     (RD1)
    );

    rf_read_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_rd2 (
        .addr      (A2),
        .regs_flat (regs_flat),
        .wr_en     (RFWr),
        .wr_addr   (A3),
        .wr_data   (WD),
        .rdata     (RD2)
    );

    // Debug port observes committed state only.
    rf_read_port #(.WIDTH(WIDTH), .BYPASS(1'b0)) u_dbg (
        .addr      (dbg_addr),
        .regs_flat (regs_flat),
        .wr_en     (1'b0),
        .wr_addr   (REG_ZERO),
        .wr_data   ('0),
        .rdata     (dbg_data)
    );

endmodule

// File: tb/tb_rf_bank.sv
// Self-checking bench for rf_bank: directed scenarios plus randomized traffic
// against an array model, on a BYPASS=0 and a BYPASS=1 instance driven in parallel.
module tb_rf_bank;

    logic        clk = 1'b0;
    logic        rstn;
    logic        RFWr;
    logic [4:0]  A1, A2, A3, dbg_addr;
    logic [31:0] WD;
    logic [31:0] RD1, RD2, dbg_data, wr_count;
    logic [31:0] bp_RD1, bp_RD2, bp_dbg_data, bp_wr_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural register contents and write counter.
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    rf_bank #(.BYPASS(1'b0)) dut (
        .clk(clk), .rstn(rstn), .RFWr(RFWr), .A1(A1), .A2(A2), .A3(A3), .WD(WD),
        .RD1(RD1), .RD2(RD2), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
    );

    rf_bank #(.BYPASS(1'b1)) dut_bp (
        .clk(clk), .rstn(rstn), .RFWr(RFWr), .A1(A1), .A2(A2), .A3(A3), .WD(WD),
        .RD1(bp_RD1), .RD2(bp_RD2), .dbg_addr(dbg_addr), .dbg_data(bp_dbg_data),
        .wr_count(bp_wr_count)
    );

    function automatic logic [31:0] reset_val(input int idx);
        if (idx == 28) return 32'h0000_1800;
        if (idx == 29) return 32'h0000_2ffc;
        return 32'h0;
    endfunction

    // One rising edge: apply the architectural rules to the model, then settle.
    task automatic step();
        @(posedge clk);
        if (!rstn) begin
            for (int i = 0; i < 32; i++) m_regs[i] = reset_val(i);
            m_cnt = 32'h0;
        end else if (RFWr && A3 != 5'd0) begin
            m_regs[A3] = WD;
            m_cnt      = m_cnt + 32'h1;
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; RFWr = 1'b0; A1 = 5'd0; A2 = 5'd0; A3 = 5'd0; WD = '0; dbg_addr = 5'd0;
        step();
        step();
        rstn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            checks++;
            if (dbg_data !== reset_val(i)) begin
                failures++;
                $display("FAIL reset_dbg[%0d] got=%h exp=%h", i, dbg_data, reset_val(i));
            end
        end
        checks++;
        if (wr_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_wr_count got=%h exp=0", wr_count);
        end
    endtask

    task automatic test_write_read();
        RFWr = 1'b1; A3 = 5'd5; WD = 32'hDEAD_BEEF; A1 = 5'd5; A2 = 5'd5;
        #1;
        checks++;
        if (RD1 !== 32'h0) begin
            failures++;
            $display("FAIL wr_before_edge RD1 got=%h exp=0", RD1);
        end
        step();
        RFWr = 1'b0;
        #1;
        checks++;
        if (RD1 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr_after RD1 got=%h exp=deadbeef", RD1);
        end
        checks++;
        if (RD2 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr_after RD2 got=%h exp=deadbeef", RD2);
        end
        checks++;
        if (wr_count !== 32'h1) begin
            failures++;
            $display("FAIL wr_count_one got=%h exp=1", wr_count);
        end
    endtask

    task automatic test_zero_reg();
        RFWr = 1'b1; A3 = 5'd0; WD = 32'hFFFF_FFFF; A1 = 5'd0;
        step();
        RFWr = 1'b0;
        #1;
        checks++;
        if (RD1 !== 32'h0) begin
            failures++;
            $display("FAIL zero_reg RD1 got=%h exp=0", RD1);
        end
        checks++;
        if (wr_count !== 32'h1) begin
            failures++;
            $display("FAIL zero_reg wr_count got=%h exp=1", wr_count);
        end
    endtask

    task automatic test_jal();
        RFWr = 1'b1; A3 = 5'd31; WD = 32'h0000_3010; dbg_addr = 5'd31;
        step();
        checks++;
        if (dbg_data !== 32'h0000_3010) begin
            failures++;
            $display("FAIL jal_ra got=%h exp=00003010", dbg_data);
        end
        RFWr = 1'b0; WD = 32'h0000_1234;
        repeat (3) step();
        checks++;
        if (dbg_data !== 32'h0000_3010) begin
            failures++;
            $display("FAIL jal_hold got=%h exp=00003010", dbg_data);
        end
    endtask

    task automatic test_reset_priority();
        rstn = 1'b0; RFWr = 1'b1; A3 = 5'd7; WD = 32'hAAAA_5555; dbg_addr = 5'd7;
        step();
        checks++;
        if (dbg_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_prio reg7 got=%h exp=0", dbg_data);
        end
        checks++;
        if (wr_count !== 32'h0) begin
            failures++;
            $display("FAIL rst_prio wr_count got=%h exp=0", wr_count);
        end
        rstn = 1'b1;
        step();
        checks++;
        if (dbg_data !== 32'hAAAA_5555) begin
            failures++;
            $display("FAIL rst_release reg7 got=%h exp=aaaa5555", dbg_data);
        end
        checks++;
        if (wr_count !== 32'h1) begin
            failures++;
            $display("FAIL rst_release wr_count got=%h exp=1", wr_count);
        end
        RFWr = 1'b0;
    endtask

    task automatic test_bypass();
        logic [31:0] old9;
        old9 = m_regs[9];
        RFWr = 1'b1; A3 = 5'd9; A1 = 5'd9; WD = 32'h0BAD_F00D; dbg_addr = 5'd9;
        #1;
        checks++;
        if (bp_RD1 !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL bypass RD1 got=%h exp=0badf00d", bp_RD1);
        end
        checks++;
        if (bp_dbg_data !== old9) begin
            failures++;
            $display("FAIL bypass_dbg got=%h exp=%h", bp_dbg_data, old9);
        end
        checks++;
        if (RD1 !== old9) begin
            failures++;
            $display("FAIL nobypass RD1 got=%h exp=%h", RD1, old9);
        end
        step();
        RFWr = 1'b0;
        #1;
        checks++;
        if (bp_dbg_data !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL bypass_commit dbg got=%h exp=0badf00d", bp_dbg_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2, eb1, eb2;
        for (int n = 0; n < 300; n++) begin
            rstn     = ($urandom_range(0, 24) != 0);
            RFWr     = $urandom_range(0, 1) == 1;
            A1       = 5'($urandom);
            A2       = ($urandom_range(0, 4) == 0) ? A1 : 5'($urandom);
            A3       = ($urandom_range(0, 2) == 0) ? A1 : 5'($urandom);
            WD       = $urandom;
            dbg_addr = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom);
            #1;
            e1  = m_regs[A1];
            e2  = m_regs[A2];
            eb1 = (RFWr && A3 != 5'd0 && A3 == A1) ? WD : e1;
            eb2 = (RFWr && A3 != 5'd0 && A3 == A2) ? WD : e2;
            checks++;
            if (RD1 !== e1) begin
                failures++;
                $display("FAIL rand[%0d] RD1 A1=%0d got=%h exp=%h", n, A1, RD1, e1);
            end
            checks++;
            if (RD2 !== e2) begin
                failures++;
                $display("FAIL rand[%0d] RD2 A2=%0d got=%h exp=%h", n, A2, RD2, e2);
            end
            checks++;
            if (dbg_data !== m_regs[dbg_addr]) begin
                failures++;
                $display("FAIL rand[%0d] dbg a=%0d got=%h exp=%h", n, dbg_addr, dbg_data, m_regs[dbg_addr]);
            end
            checks++;
            if (bp_RD1 !== eb1 || bp_RD2 !== eb2) begin
                failures++;
                $display("FAIL rand[%0d] bypass got=%h/%h exp=%h/%h", n, bp_RD1, bp_RD2, eb1, eb2);
            end
            checks++;
            if (bp_dbg_data !== m_regs[dbg_addr]) begin
                failures++;
                $display("FAIL rand[%0d] bp_dbg got=%h exp=%h", n, bp_dbg_data, m_regs[dbg_addr]);
            end
            step();
            checks++;
            if (wr_count !== m_cnt || bp_wr_count !== m_cnt) begin
                failures++;
                $display("FAIL rand[%0d] wr_count got=%h/%h exp=%h", n, wr_count, bp_wr_count, m_cnt);
            end
        end
        rstn = 1'b1;
        RFWr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 32'h0;
        #2;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_jal();
        test_reset_priority();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rf_bank.md
Name: rf_bank

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS core.
- Sits between the destination/write-back selection muxes and the ALU operand muxes:
  - consumes the selected destination index (A3) and the selected write-back data (RFWD/WD);
  - produces RD1/RD2, which feed the ALU operand-A and operand-B muxes.
- Two combinational read ports, one synchronous write port, one debug read port; $0 hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register.
- SP_INIT, 32'h0000_2ffc, reset value of register 29 ($sp).
- GP_INIT, 32'h0000_1800, reset value of register 28 ($gp).
- BYPASS, 0, 1 = same-cycle write-to-read forwarding. Must stay 0 in the single-cycle core: WD depends on RD1/RD2, so forwarding would close a combinational loop. Intended for pipelined reuse only.

Ports:
- clk  in  1  system clock, rising edge active.
- rstn  in  1  synchronous active-low reset, sampled on rising clk.
- RFWr  in  1  write enable from control.
- A1  in  5  read port 1 index (rs).
- A2  in  5  read port 2 index (rt).
- A3  in  5  write index, from the destination mux (rt/rd/31).
- WD  in  WIDTH  write data, from the write-back mux.
- RD1  out  WIDTH  read data, port 1.
- RD2  out  WIDTH  read data, port 2.
- dbg_addr  in  5  debug/testbench read index.
- dbg_data  out  WIDTH  debug read data.
- wr_count  out  32  number of committed writes since reset (diagnostic).

Behaviour:
- Storage: regs[1..31] are flops. regs[0] does not exist; reads of index 0 return 0.
- Reset: on a rising clk with rstn==0:
  - regs[1..31] <= 0, except regs[28] <= GP_INIT and regs[29] <= SP_INIT;
  - wr_count <= 0.
  - Reset takes priority over a simultaneous write.
  - Reset value of outputs: RD1/RD2/dbg_data show the post-reset register contents for the current indices (0 for most indices); wr_count = 0.
- Write: on a rising clk with rstn==1 and RFWr==1 and A3!=0:
  - regs[A3] <= WD;
  - wr_count <= wr_count+1, wrapping 32'hFFFF_FFFF -> 0.
  - A3==0 with RFWr==1 is silently dropped; wr_count unchanged.
  - RFWr==0: no state change.
- Read, BYPASS=0:
  - RD1 = (A1==0) ? 0 : regs[A1]; RD2 likewise from A2.
  - Purely combinational, zero latency.
  - A write becomes visible on the read ports in the cycle after the edge that commits it.
- Read, BYPASS=1: if RFWr && A3!=0 && A3==Ax, then RDx = WD combinationally (write-first); otherwise as for BYPASS=0.
- Same index on A1 and A2: both ports return identical data.
- dbg_data follows the same rule as RD1, using dbg_addr, and is never bypassed.
- Widths:
  - no sign or zero extension inside the block;
  - WD is stored verbatim;
  - indices are full 5-bit, with no out-of-range case.
- X handling: RFWr==X during simulation is a bench error; the RTL need not resolve it.
- Reset mid-operation: a write pending on the same edge as rstn==0 is lost; the first write after reset is accepted on the first edge with rstn==1.

Decomposition:
- Register indices 0, 28, 29, 31 and the RegDst/ToReg encodings remain in the shared ctrl_encode_def.v. Add `REG_ZERO, `REG_GP, `REG_SP, `REG_RA there.
- One optional sub-module, rf_read_port: index-to-data selection with the zero-index and bypass logic. It is instantiated three times (RD1, RD2, dbg), with bypass tied off for dbg.

Test Plan:
- Reset: rstn=0 for 2 cycles, then release.
  - dbg_addr sweep 0..31 -> all 0, except reg28=0x00001800 and reg29=0x00002ffc.
  - wr_count=0.
- Write/read: RFWr=1, A3=5, WD=0xDEADBEEF, one edge; then A1=5, A2=5.
  - RD1=RD2=0xDEADBEEF in the next cycle.
  - wr_count=1.
  - Before the edge, RD1 still reads 0 (BYPASS=0).
- $0 protection: RFWr=1, A3=0, WD=0xFFFFFFFF.
  - A1=0 -> RD1=0.
  - wr_count unchanged.
- Jal path: A3=31 (RA), WD=0x00003010 -> dbg_addr=31 shows 0x00003010.
  - Then RFWr=0, A3=31, WD=0x1234 for 3 edges -> reg31 remains 0x00003010.
- Reset priority: rstn=0 and RFWr=1, A3=7, WD=0xAAAA5555 on the same edge.
  - reg7=0, wr_count=0.
  - Next edge with rstn=1 and the same write -> reg7=0xAAAA5555.
- BYPASS=1 build: RFWr=1, A3=A1=9, WD=0x0BADF00D.
  - RD1=0x0BADF00D in the same cycle.
  - dbg_addr=9 still shows the old value until the edge.
